// File: rtl/clk_counter_pkg.sv
// clk_counter_pkg
// Shared constants for the clock-divide counter block.
//   DEFAULT_WIDTH : default width of the general-purpose up-counter.
//   MIN_WIDTH / MAX_WIDTH : supported range for the counter width.
package clk_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;
  localparam int unsigned MIN_WIDTH     = 32'd2;
  localparam int unsigned MAX_WIDTH     = 32'd32;

endpackage : clk_counter_pkg

// File: rtl/clk_counter_clk_toggle.sv
// clk_toggle
// Single divide-by-2 stage: a toggle flop that inverts on every rising clk
// edge. It is cleared asynchronously, so the first edge after reset release
// drives the output high. Stages can be chained for further division.
// Ports:
//   clk   in  : input clock
//   rst_n in  : asynchronous active-low reset
//   q     out : clk / 2, 50% duty, straight from the flop
module clk_toggle (
  input  logic clk,
  input  logic rst_n,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state is always the inverse of the current state.
  always_comb begin
    q_d = ~q_q;
  end

  // Toggle register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : clk_toggle

// File: rtl/clk_counter.sv
// clk_counter
// Free-running clock divider plus general-purpose up-counter.
// Ports:
//   clk   in         : system clock, all state changes on its rising edge
//   rst_n in         : asynchronous active-low reset (release must be
//                      synchronised to clk externally)
//   en    in         : count enable (does not affect clk2)
//   clr   in         : synchronous clear of count (does not affect clk2)
//   clk2  out        : clk / 2, 50% duty, registered
//   count out [W-1:0]: current counter value, registered
//   wrap  out        : one-cycle pulse in the cycle count reads 0 after
//                      incrementing from all-ones
// WIDTH is supported from MIN_WIDTH to MAX_WIDTH (see package).
module clk_counter
  import clk_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             clk2,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  // Divide-by-2 output; independent of en and clr.
  clk_toggle u_clk_toggle (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (clk2)
  );

  // Counter next state: clear beats enable; wrap only on a real rollover.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = ZERO;
      wrap_d  = 1'b0;
    end else if (en) begin
      count_d = count_q + ONE;
      wrap_d  = (count_q == ALL_ONES);
    end else begin
      count_d = count_q;
      wrap_d  = 1'b0;
    end
  end

  // Count and wrap registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule : clk_counter

// File: tb/tb_clk_counter.sv
`timescale 1ns/100ps
// tb_clk_counter
// Directed bench for clk_counter (WIDTH=8): reset, divide-by-2, counting and
// rollover, hold, clear priority, hold at all-ones, and asynchronous
// mid-run reset. Outputs are sampled on the falling clk edge.
module tb_clk_counter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic         clk2;
  logic [W-1:0] count;
  logic         wrap;

  int           n_tests;
  int           n_fail;
  logic         exp_clk2;
  realtime      t_rise_prev;
  realtime      t_rise_last;

  clk_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .clk2  (clk2),
    .count (count),
    .wrap  (wrap)
  );

  // 2 ns clock period.
  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Record the last two rising edges of clk2 for the period measurement.
  initial begin
    t_rise_prev = 0.0;
    t_rise_last = 0.0;
  end
  always @(posedge clk2) begin
    t_rise_prev = t_rise_last;
    t_rise_last = $realtime;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, update the clk2 model, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    exp_clk2 = ~exp_clk2;
    @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_clk2 = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;

    // Reset held for 3 cycles: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_clk2", 32'(clk2), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
    end

    // Release away from the rising edge; divide-by-2 with en=0.
    rst_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      check("div_clk2", 32'(clk2), 32'(i % 2));
      check("div_count", 32'(count), 32'd0);
    end
    check("clk2_period_x10", 32'(int'((t_rise_last - t_rise_prev) * 10.0)), 32'd40);

    // Count 256 edges: 1..255 then rollover to 0 with a wrap pulse.
    en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      step();
      check("cnt_count", 32'(count), 32'(k % 256));
      check("cnt_wrap", 32'(wrap), (k == 256) ? 32'd1 : 32'd0);
    end
    step();
    check("post_wrap_count", 32'(count), 32'd1);
    check("post_wrap_wrap", 32'(wrap), 32'd0);

    // Reach 100, then hold for 5 cycles with en=0.
    for (int k = 0; k < 99; k++) step();
    check("pre_hold_count", 32'(count), 32'd100);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_count", 32'(count), 32'd100);
      check("hold_clk2", 32'(clk2), 32'(exp_clk2));
      check("hold_wrap", 32'(wrap), 32'd0);
    end

    // Up to 255, then clr together with en: clear wins, no wrap.
    en = 1'b1;
    for (int k = 0; k < 155; k++) step();
    check("pre_clr_count", 32'(count), 32'd255);
    clr = 1'b1;
    step();
    check("clr_count", 32'(count), 32'd0);
    check("clr_wrap", 32'(wrap), 32'd0);
    clr = 1'b0;

    // Up to 255, then en drops: count holds at all-ones, no wrap.
    for (int k = 0; k < 255; k++) step();
    check("pre_stall_count", 32'(count), 32'd255);
    en = 1'b0;
    step();
    check("stall_count", 32'(count), 32'd255);
    check("stall_wrap", 32'(wrap), 32'd0);
    en = 1'b1;
    step();
    check("late_wrap_count", 32'(count), 32'd0);
    check("late_wrap_wrap", 32'(wrap), 32'd1);

    // Reach 37 with clk2 high.
    for (int k = 0; k < 36; k++) step();
    if (exp_clk2) begin
      en = 1'b0;
      step();
      en = 1'b1;
    end
    step();
    check("pre_rst_count", 32'(count), 32'd37);
    check("pre_rst_clk2", 32'(clk2), 32'd1);

    // Asynchronous reset in the low phase of clk: outputs clear at once.
    #0.3;
    rst_n = 1'b0;
    #0.2;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_clk2", 32'(clk2), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    #0.2;
    rst_n    = 1'b1;
    exp_clk2 = 1'b0;
    step();
    check("after_rst_clk2", 32'(clk2), 32'd1);
    check("after_rst_count", 32'(count), 32'd1);
    step();
    check("after_rst_clk2_b", 32'(clk2), 32'd0);
    check("after_rst_count_b", 32'(count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_clk_counter
